// File: rtl/pe_array.sv
// 16x16 output-stationary systolic grid of FP32 multiply-accumulate PEs.
// x operands enter on the west edge and move east one PE per clock; y operands
// enter on the north edge and move south one PE per clock. Every PE adds
// x*y into its own accumulator on every edge. A registered read port returns
// any single accumulator.
//
// Read port: rdn is an active-low strobe with no handshake. On a rising edge
// with rdn = 0, output_value captures the pre-edge accumulator at
// (row = y_position, col = x_position), or zero if either index is >= 16.
// With rdn = 1, output_value holds. Reading never disturbs accumulation.
module pe_array (
    input  logic        master_clock,
    input  logic        reset_n,
    input  logic [31:0] x_inputs0,
    input  logic [31:0] x_inputs1,
    input  logic [31:0] x_inputs2,
    input  logic [31:0] x_inputs3,
    input  logic [31:0] x_inputs4,
    input  logic [31:0] x_inputs5,
    input  logic [31:0] x_inputs6,
    input  logic [31:0] x_inputs7,
    input  logic [31:0] x_inputs8,
    input  logic [31:0] x_inputs9,
    input  logic [31:0] x_inputs10,
    input  logic [31:0] x_inputs11,
    input  logic [31:0] x_inputs12,
    input  logic [31:0] x_inputs13,
    input  logic [31:0] x_inputs14,
    input  logic [31:0] x_inputs15,
    input  logic [31:0] y_inputs0,
    input  logic [31:0] y_inputs1,
    input  logic [31:0] y_inputs2,
    input  logic [31:0] y_inputs3,
    input  logic [31:0] y_inputs4,
    input  logic [31:0] y_inputs5,
    input  logic [31:0] y_inputs6,
    input  logic [31:0] y_inputs7,
    input  logic [31:0] y_inputs8,
    input  logic [31:0] y_inputs9,
    input  logic [31:0] y_inputs10,
    input  logic [31:0] y_inputs11,
    input  logic [31:0] y_inputs12,
    input  logic [31:0] y_inputs13,
    input  logic [31:0] y_inputs14,
    input  logic [31:0] y_inputs15,
    input  logic [7:0]  x_position,
    input  logic [7:0]  y_position,
    input  logic        rdn,
    output logic [31:0] output_value
);

    // reset_n is active-high despite its name.
    logic rst;
    assign rst = reset_n;

    logic [31:0] x_edge [0:15];
    logic [31:0] y_edge [0:15];
    logic [31:0] x_reg  [0:15][0:15];
    logic [31:0] y_reg  [0:15][0:15];
    logic [31:0] acc    [0:15][0:15];
    logic [31:0] x_in   [0:15][0:15];
    logic [31:0] y_in   [0:15][0:15];
    logic [31:0] acc_nx [0:15][0:15];

    assign x_edge[0]  = x_inputs0;   assign y_edge[0]  = y_inputs0;
    assign x_edge[1]  = x_inputs1;   assign y_edge[1]  = y_inputs1;
    assign x_edge[2]  = x_inputs2;   assign y_edge[2]  = y_inputs2;
    assign x_edge[3]  = x_inputs3;   assign y_edge[3]  = y_inputs3;
    assign x_edge[4]  = x_inputs4;   assign y_edge[4]  = y_inputs4;
    assign x_edge[5]  = x_inputs5;   assign y_edge[5]  = y_inputs5;
    assign x_edge[6]  = x_inputs6;   assign y_edge[6]  = y_inputs6;
    assign x_edge[7]  = x_inputs7;   assign y_edge[7]  = y_inputs7;
    assign x_edge[8]  = x_inputs8;   assign y_edge[8]  = y_inputs8;
    assign x_edge[9]  = x_inputs9;   assign y_edge[9]  = y_inputs9;
    assign x_edge[10] = x_inputs10;  assign y_edge[10] = y_inputs10;
    assign x_edge[11] = x_inputs11;  assign y_edge[11] = y_inputs11;
    assign x_edge[12] = x_inputs12;  assign y_edge[12] = y_inputs12;
    assign x_edge[13] = x_inputs13;  assign y_edge[13] = y_inputs13;
    assign x_edge[14] = x_inputs14;  assign y_edge[14] = y_inputs14;
    assign x_edge[15] = x_inputs15;  assign y_edge[15] = y_inputs15;

    // FP32 multiply: denormals act as signed zero, truncating, saturates to inf.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hff || b[30:23] == 8'hff) return {s, 8'hff, 23'h0};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = $signed({24'd0, a[30:23]}) + $signed({24'd0, b[30:23]}) - 127 + (p[47] ? 1 : 0);
        if (e >= 255) return {s, 8'hff, 23'h0};
        if (e <= 0) return 32'h0;
        return {s, e[7:0], (p[47] ? p[46:24] : p[45:23])};
    endfunction

    // FP32 add: 26 extra alignment bits plus a sticky bit keep truncation exact.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] big;
        logic [31:0] sml;
        logic [7:0]  d;
        logic [49:0] m_big;
        logic [49:0] m_full;
        logic [49:0] m_sml;
        logic [50:0] sum;
        logic [50:0] norm;
        int          pos;
        int          e;
        if (a[30:23] == 8'hff) return {a[31], 8'hff, 23'h0};
        if (b[30:23] == 8'hff) return {b[31], 8'hff, 23'h0};
        if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'h0};
        if (a[30:23] == 8'h00) return b;
        if (b[30:23] == 8'h00) return a;
        if (a[30:0] >= b[30:0]) begin
            big = a; sml = b;
        end else begin
            big = b; sml = a;
        end
        d      = big[30:23] - sml[30:23];
        m_big  = {1'b1, big[22:0], 26'h0};
        m_full = {1'b1, sml[22:0], 26'h0};
        m_sml  = m_full >> d;
        m_sml[0] = m_sml[0] | ((m_sml << d) != m_full);
        if (big[31] == sml[31]) sum = {1'b0, m_big} + {1'b0, m_sml};
        else                    sum = {1'b0, m_big} - {1'b0, m_sml};
        if (sum == 51'h0) return 32'h0;
        pos = 0;
        for (int i = 0; i < 51; i++) if (sum[i]) pos = i;
        norm = sum << (50 - pos);
        e = $signed({24'd0, big[30:23]}) + pos - 49;
        if (e >= 255) return {big[31], 8'hff, 23'h0};
        if (e <= 0) return 32'h0;
        return {big[31], e[7:0], norm[49:27]};
    endfunction

    // Operand routing from the grid edges or the neighbour PE, then MAC per PE.
    always_comb begin
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                x_in[r][c] = x_edge[r];
                y_in[r][c] = y_edge[c];
                if (c != 0) x_in[r][c] = x_reg[r][c-1];
                if (r != 0) y_in[r][c] = y_reg[r-1][c];
                acc_nx[r][c] = fp_add(acc[r][c], fp_mul(x_in[r][c], y_in[r][c]));
            end
        end
    end

    // Shift operands through the grid and accumulate continuously.
    always_ff @(posedge master_clock or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 16; r++) begin
                for (int c = 0; c < 16; c++) begin
                    x_reg[r][c] <= 32'h0;
                    y_reg[r][c] <= 32'h0;
                    acc[r][c]   <= 32'h0;
                end
            end
        end else begin
            for (int r = 0; r < 16; r++) begin
                for (int c = 0; c < 16; c++) begin
                    x_reg[r][c] <= x_in[r][c];
                    y_reg[r][c] <= y_in[r][c];
                    acc[r][c]   <= acc_nx[r][c];
                end
            end
        end
    end

    // Registered addressed readout of one accumulator.
    always_ff @(posedge master_clock or posedge rst) begin
        if (rst) begin
            output_value <= 32'h0;
        end else if (!rdn) begin
            if (x_position < 8'd16 && y_position < 8'd16)
                output_value <= acc[y_position[3:0]][x_position[3:0]];
            else
                output_value <= 32'h0;
        end
    end

endmodule

// File: tb/tb_pe_array.sv
// Directed bench for pe_array: reset, MAC and skew, drain, read control and
// FP32 corner cases, all observed through the read port.
`timescale 1ns/1ps
module tb_pe_array;

    logic        master_clock;
    logic        reset_n;
    logic [31:0] xv [0:15];
    logic [31:0] yv [0:15];
    logic [7:0]  x_position;
    logic [7:0]  y_position;
    logic        rdn;
    logic [31:0] output_value;

    int n_vec;
    int n_bad;
    logic [31:0] v;

    pe_array dut (
        .master_clock(master_clock), .reset_n(reset_n),
        .x_inputs0(xv[0]),   .x_inputs1(xv[1]),   .x_inputs2(xv[2]),   .x_inputs3(xv[3]),
        .x_inputs4(xv[4]),   .x_inputs5(xv[5]),   .x_inputs6(xv[6]),   .x_inputs7(xv[7]),
        .x_inputs8(xv[8]),   .x_inputs9(xv[9]),   .x_inputs10(xv[10]), .x_inputs11(xv[11]),
        .x_inputs12(xv[12]), .x_inputs13(xv[13]), .x_inputs14(xv[14]), .x_inputs15(xv[15]),
        .y_inputs0(yv[0]),   .y_inputs1(yv[1]),   .y_inputs2(yv[2]),   .y_inputs3(yv[3]),
        .y_inputs4(yv[4]),   .y_inputs5(yv[5]),   .y_inputs6(yv[6]),   .y_inputs7(yv[7]),
        .y_inputs8(yv[8]),   .y_inputs9(yv[9]),   .y_inputs10(yv[10]), .y_inputs11(yv[11]),
        .y_inputs12(yv[12]), .y_inputs13(yv[13]), .y_inputs14(yv[14]), .y_inputs15(yv[15]),
        .x_position(x_position), .y_position(y_position),
        .rdn(rdn), .output_value(output_value)
    );

    // Clock: 10 ns period.
    initial master_clock = 1'b0;
    always #5 master_clock = ~master_clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic set_all(input logic [31:0] x, input logic [31:0] y);
        for (int i = 0; i < 16; i++) begin
            xv[i] = x;
            yv[i] = y;
        end
    endtask

    // Advance n rising edges, leaving time 1 ns past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge master_clock);
        #1;
    endtask

    // One read edge at (row, col); returns output_value after the edge.
    task automatic read_pe(input logic [7:0] row, input logic [7:0] col, output logic [31:0] val);
        y_position = row;
        x_position = col;
        rdn = 1'b0;
        tick(1);
        rdn = 1'b1;
        val = output_value;
    endtask

    // Pulse reset between edges, then apply x/y from the release on.
    task automatic restart(input logic [31:0] x, input logic [31:0] y);
        #1;
        reset_n = 1'b1;
        #1;
        set_all(x, y);
        reset_n = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset_n = 1'b1;
        rdn = 1'b1;
        x_position = 8'd0;
        y_position = 8'd0;
        set_all(32'h3F800000, 32'h40000000);

        // Reset held: reads return zero regardless of inputs.
        tick(1);
        read_pe(8'd0, 8'd0, v);
        check_eq("rst_out_00", v, 32'h0);
        read_pe(8'd7, 8'd9, v);
        check_eq("rst_out_79", v, 32'h0);

        // Basic MAC: 2.0*3.0 for 4 edges -> 24.0.
        restart(32'h40000000, 32'h40400000);
        tick(4);
        read_pe(8'd0, 8'd0, v);
        check_eq("mac_00", v, 32'h41C00000);

        // Skew after 4 edges.
        restart(32'h40000000, 32'h40400000);
        tick(4);
        read_pe(8'd3, 8'd0, v);
        check_eq("skew_30", v, 32'h40C00000);
        restart(32'h40000000, 32'h40400000);
        tick(4);
        read_pe(8'd5, 8'd2, v);
        check_eq("skew_52", v, 32'h0);
        restart(32'h40000000, 32'h40400000);
        tick(4);
        read_pe(8'd2, 8'd3, v);
        check_eq("skew_23", v, 32'h40C00000);

        // Far corner: zero at 10 edges, (20-15)*6 = 30.0 at 20 edges.
        restart(32'h40000000, 32'h40400000);
        tick(10);
        read_pe(8'd15, 8'd15, v);
        check_eq("corner_k10", v, 32'h0);
        restart(32'h40000000, 32'h40400000);
        tick(20);
        read_pe(8'd15, 8'd15, v);
        check_eq("corner_k20", v, 32'h41F00000);

        // Drain: nonzero for edges 1..4, zeros afterwards.
        restart(32'h40000000, 32'h40400000);
        tick(4);
        set_all(32'h0, 32'h0);
        read_pe(8'd0, 8'd0, v);           // edge 5
        check_eq("drain_00", v, 32'h41C00000);
        read_pe(8'd15, 8'd15, v);         // edge 6
        check_eq("drain_ff_early", v, 32'h0);
        tick(11);                         // edges 7..17
        read_pe(8'd15, 8'd15, v);         // edge 18: edges 16,17 counted
        check_eq("drain_ff_mid", v, 32'h41400000);
        tick(6);                          // edges 19..24
        read_pe(8'd15, 8'd15, v);         // edge 25
        check_eq("drain_ff_done", v, 32'h41C00000);
        read_pe(8'd0, 8'd0, v);
        check_eq("drain_00_frozen", v, 32'h41C00000);

        // Read control: hold with rdn high, then out-of-range addresses.
        x_position = 8'd5;
        y_position = 8'd11;
        tick(4);
        check_eq("hold", output_value, 32'h41C00000);
        read_pe(8'd0, 8'd16, v);
        check_eq("oob_x16", v, 32'h0);
        read_pe(8'd0, 8'd0, v);
        check_eq("reread_00", v, 32'h41C00000);
        read_pe(8'd200, 8'd0, v);
        check_eq("oob_y200", v, 32'h0);
        read_pe(8'd0, 8'd0, v);

        // Reset between edges clears output and accumulators at once.
        #3;
        reset_n = 1'b1;
        #1;
        check_eq("async_rst_out", output_value, 32'h0);
        reset_n = 1'b0;
        tick(1);
        read_pe(8'd0, 8'd0, v);
        check_eq("async_rst_acc", v, 32'h0);

        // Overflow in the multiplier saturates to +inf.
        restart(32'h7F000000, 32'h40000000);
        tick(1);
        set_all(32'h0, 32'h0);
        read_pe(8'd0, 8'd0, v);
        check_eq("fp_inf", v, 32'h7F800000);

        // Denormal operand contributes nothing.
        restart(32'h00000001, 32'h40400000);
        tick(3);
        read_pe(8'd0, 8'd0, v);
        check_eq("fp_denorm", v, 32'h0);

        // -1 then +1 cancels back to +0.
        restart(32'hBF800000, 32'h3F800000);
        tick(1);
        set_all(32'h3F800000, 32'h3F800000);
        read_pe(8'd0, 8'd0, v);
        check_eq("fp_neg1", v, 32'hBF800000);
        set_all(32'h0, 32'h0);
        read_pe(8'd0, 8'd0, v);
        check_eq("fp_cancel", v, 32'h0);

        // Negative products accumulate, then a smaller positive one subtracts.
        restart(32'h40000000, 32'hBF000000);
        tick(3);
        set_all(32'h40000000, 32'h3F000000);
        read_pe(8'd0, 8'd0, v);           // -3.0, then +1.0 added on this edge
        check_eq("fp_neg3", v, 32'hC0400000);
        set_all(32'h0, 32'h0);
        read_pe(8'd0, 8'd0, v);
        check_eq("fp_sub", v, 32'hC0000000);

        // Product truncation: (1.5+2^-23)^2 drops 0.5 ulp.
        restart(32'h3FC00001, 32'h3FC00001);
        tick(1);
        set_all(32'h0, 32'h0);
        read_pe(8'd0, 8'd0, v);
        check_eq("fp_trunc", v, 32'h40100001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pe_array.md
Name: pe_array

Overview:
- 16x16 output-stationary systolic grid of IEEE-754 single-precision multiply-accumulate processing elements (PEs); the core compute fabric of the TPU datapath.
- Row operands (x) enter at the west edge and shift east one PE per clock; column operands (y) enter at the north edge and shift south one PE per clock.
- Each PE accumulates x*y locally. Any single accumulator is read out through an addressed, registered read port.

Parameters:
- none. Fixed: 16 rows, 16 columns, 32-bit FP32 data, 8-bit position addresses.

Ports:
- master_clock  in  1  sole clock, rising-edge active
- reset_n  in  1  asynchronous reset, active-high (asserted when 1) despite the name; clears all state
- x_inputs0..x_inputs15  in  32 each  FP32 operand for row r = 0..15, west edge
- y_inputs0..y_inputs15  in  32 each  FP32 operand for column c = 0..15, north edge
- x_position  in  8  column index of the PE to read
- y_position  in  8  row index of the PE to read
- rdn  in  1  read strobe, active-low
- output_value  out  32  registered FP32 accumulator readout

Behaviour:
- PE(r,c) operand sources:
  - x_in = x_inputs r when c = 0, else x_reg of PE(r,c-1).
  - y_in = y_inputs c when r = 0, else y_reg of PE(r-1,c).
- Every rising edge with reset deasserted, each PE updates: x_reg <= x_in; y_reg <= y_in; acc <= acc + x_in*y_in. There is no enable; accumulation is continuous.
- Skew: PE(r,c) sees the edge inputs delayed by max(r,c) cycles in effect. With constant nonzero inputs applied from reset release, after k edges acc(r,c) = (k - max(r,c)) * p when k > max(r,c), else +0.
- Reset (reset_n = 1, asynchronous): every x_reg, y_reg and acc = +0 (32'h0); output_value = 32'h0. Reset asserted mid-operation clears immediately regardless of clock. Accumulation restarts from the first edge after release.
- Readout:
  - On a rising edge with rdn = 0: output_value <= pre-edge acc of PE(row = y_position, col = x_position).
  - If x_position >= 16 or y_position >= 16: output_value <= 32'h0.
  - rdn = 1: output_value holds its value.
  - Latency is 1 edge. The read does not disturb accumulation.
- FP32 arithmetic, used by both multiplier and adder:
  - Zero or denormal operands are treated as signed zero.
  - Results are normalised, rounded toward zero (truncate).
  - Exponent overflow produces signed infinity (exp 255, mantissa 0).
  - Exponent underflow produces +0.
  - Any operand with exponent 255 yields signed infinity.
  - Exact cancellation in the adder gives +0.
  - No NaN generation and no exception flags.
- Combinational path per PE: multiply then add, within one cycle. Pipelining inside a PE is not permitted, as it would change the skew relation above.

Test Plan:
- Reset: assert reset_n = 1 with arbitrary inputs, pulse rdn = 0 for one edge at any position -> output_value = 32'h00000000; all accumulators read 0.
- Basic MAC: all x = 32'h40000000 (2.0), all y = 32'h40400000 (3.0). Release reset and run 4 edges. Read PE(0,0) with rdn = 0 on edge 5 -> output_value = 32'h41C00000 (24.0).
- Skew: same stimulus, 4 edges. Read (y=3,x=0) -> 32'h40C00000 (6.0). Read (y=5,x=2) -> 32'h00000000. Read (y=2,x=3) -> 32'h40C00000 (6.0).
- Drain: after the Basic MAC sequence, drive all inputs to 32'h0 -> PE(0,0) freezes at 24.0 on subsequent edges. PE(15,15) keeps accumulating 6.0 per edge until zeros reach it, then holds.
- Read control:
  - rdn = 1 for several edges -> output_value unchanged.
  - x_position = 8'd16 with rdn = 0 -> 32'h0.
  - Reset asserted between clock edges -> output_value and all acc go to 0 immediately.
- FP corners:
  - x = 32'h7F000000, y = 32'h40000000 -> PE(0,0) acc = 32'h7F800000 (+inf) after 1 edge.
  - x = 32'h00000001 (denormal) -> product contributes 0.
  - x = -1.0 (32'hBF800000) at edge 1, then +1.0, with y = 1.0 -> PE(0,0) acc returns to 32'h00000000.
